// File: rtl/exec_trace_monitor.sv
// Execution trace monitor for the unicycle MIPS core: captures one entry per cycle
// into a circular buffer, freezes on halt opcode or watchdog, then drains oldest-first.
module exec_trace_monitor #(
    parameter int                 DATA_W   = 8,
    parameter int                 PC_W     = 8,
    parameter int                 INST_W   = 8,
    parameter int                 OPC_W    = 3,
    parameter logic [OPC_W-1:0]   HALT_OPC = 3'b111,
    parameter int                 DEPTH    = 16,
    parameter int                 TIMEOUT  = 1024,
    parameter int                 CNT_W    = 16
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [PC_W-1:0]           pc,
    input  logic [INST_W-1:0]         inst,
    input  logic                      reg_we,
    input  logic [DATA_W-1:0]         reg_wdata,
    input  logic                      mem_we,
    input  logic [DATA_W-1:0]         mem_wdata,
    input  logic                      rd_req,
    output logic                      rd_valid,
    output logic [PC_W-1:0]           rd_pc,
    output logic [INST_W-1:0]         rd_inst,
    output logic [1:0]                rd_flags,
    output logic [DATA_W-1:0]         rd_data,
    output logic [1:0]                state,
    output logic                      done,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    count,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [CNT_W-1:0]          inst_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNTH_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [1:0]        flags;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        sRun     = 2'd0,
        sHalted  = 2'd1,
        sTimeout = 2'd2
    } state_t;

    entry_t             buffer [DEPTH];
    entry_t             newEntry;
    entry_t             headEntry;
    state_t             curState, nextState;
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [CNT_W-1:0]   cycleNext;
    logic               capture, isHalt, full, pop;

    assign capture   = (curState == sRun);
    assign isHalt    = (inst[INST_W-1 -: OPC_W] == HALT_OPC);
    assign cycleNext = cycle_cnt + CNT_W'(1);
    assign full      = (count == CNTH_W'(DEPTH));
    assign done      = (curState != sRun);
    assign rd_valid  = done && (count != '0);
    assign pop       = rd_valid && rd_req;
    assign state     = curState;

    // Register write-back takes priority when both writes fire in one cycle.
    always_comb begin
        newEntry.pc    = pc;
        newEntry.inst  = inst;
        newEntry.flags = {reg_we, mem_we};
        newEntry.data  = '0;
        if (reg_we)
            newEntry.data = reg_wdata;
        else if (mem_we)
            newEntry.data = mem_wdata;
    end

    always_comb begin
        nextState = curState;
        if (capture) begin
            if (isHalt)
                nextState = sHalted;
            else if (cycleNext == CNT_W'(TIMEOUT))
                nextState = sTimeout;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset)
            curState <= sRun;
        else
            curState <= nextState;
    end

    // Trace RAM is deliberately not reset; count alone says what is valid.
    always_ff @(posedge CLK) begin
        if (!Reset && capture)
            buffer[wrPtr] <= newEntry;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else if (capture) begin
            wrPtr     <= wrPtr + PTR_W'(1);
            cycle_cnt <= cycleNext;
            inst_cnt  <= inst_cnt + CNT_W'(1);
            if (full) begin
                rdPtr    <= rdPtr + PTR_W'(1);
                overflow <= 1'b1;
            end else begin
                count <= count + CNTH_W'(1);
            end
        end else if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
            count <= count - CNTH_W'(1);
        end
    end

    assign headEntry = buffer[rdPtr];
    assign rd_pc     = headEntry.pc;
    assign rd_inst   = headEntry.inst;
    assign rd_flags  = headEntry.flags;
    assign rd_data   = headEntry.data;

endmodule

// File: tb/tb_exec_trace_monitor.sv
// Directed bench for exec_trace_monitor (DEPTH=16, TIMEOUT=32).
module tb_exec_trace_monitor;
    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  pc, inst, reg_wdata, mem_wdata;
    logic        reg_we, mem_we, rd_req;
    logic        rd_valid, done, overflow;
    logic [7:0]  rd_pc, rd_inst, rd_data;
    logic [1:0]  rd_flags, state;
    logic [4:0]  count;
    logic [15:0] cycle_cnt, inst_cnt;

    int total = 0;
    int passed = 0;

    exec_trace_monitor #(.DEPTH(16), .TIMEOUT(32)) dut (
        .CLK(CLK), .Reset(Reset), .pc(pc), .inst(inst),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
        .rd_flags(rd_flags), .rd_data(rd_data), .state(state), .done(done),
        .overflow(overflow), .count(count), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       regWe;
        logic [7:0] regData;
        logic       memWe;
        logic [7:0] memData;
        logic [1:0] expFlags;
        logic [7:0] expData;
    } wbVec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic doReset();
        Reset = 1'b1; rd_req = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic cap(input logic [7:0] p, input logic [7:0] i);
        pc = p; inst = i;
        tick();
    endtask

    task automatic checkCleared(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_rdvalid"}, rd_valid, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_cyc"}, cycle_cnt, 0);
        check({tag, "_inst"}, inst_cnt, 0);
    endtask

    wbVec_t wbVecs[4];

    initial begin
        wbVecs[0] = '{1'b1, 8'h2A, 1'b0, 8'h99, 2'b10, 8'h2A};
        wbVecs[1] = '{1'b0, 8'h77, 1'b1, 8'h55, 2'b01, 8'h55};
        wbVecs[2] = '{1'b1, 8'h3C, 1'b1, 8'hC3, 2'b11, 8'h3C};
        wbVecs[3] = '{1'b0, 8'h11, 1'b0, 8'h22, 2'b00, 8'h00};

        pc = 0; inst = 0; reg_we = 0; reg_wdata = 0; mem_we = 0; mem_wdata = 0;
        rd_req = 0; Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        checkCleared("reset");

        // Basic halt and full drain
        for (int i = 0; i < 5; i++) cap(8'(i), 8'h20);
        check("pre_halt_state", state, 0);
        cap(8'd5, 8'hE0);
        check("halt_state", state, 1);
        check("halt_done", done, 1);
        check("halt_count", count, 6);
        check("halt_instcnt", inst_cnt, 6);
        check("halt_cyccnt", cycle_cnt, 6);
        check("halt_ovf", overflow, 0);
        cap(8'd99, 8'h20);
        check("frozen_count", count, 6);
        check("frozen_cyc", cycle_cnt, 6);
        for (int i = 0; i < 6; i++) begin
            check("drain1_valid", rd_valid, 1);
            check("drain1_pc", rd_pc, i);
            check("drain1_inst", rd_inst, (i == 5) ? 8'hE0 : 8'h20);
            rd_req = 1'b1;
            tick();
        end
        check("drain1_empty", rd_valid, 0);
        check("drain1_count", count, 0);
        tick();
        check("drain1_req_empty", count, 0);
        rd_req = 1'b0;

        // Partial drain then reset, and rd_req in RUN is ignored
        doReset();
        for (int i = 0; i < 5; i++) cap(8'(i), 8'h20);
        cap(8'd5, 8'hE0);
        rd_req = 1'b1;
        tick(); tick(); tick();
        rd_req = 1'b0;
        check("part_count", count, 3);
        check("part_head", rd_pc, 3);
        Reset = 1'b1; tick(); Reset = 1'b0;
        checkCleared("rst2");
        rd_req = 1'b1;
        cap(8'h40, 8'h20);
        cap(8'h41, 8'h20);
        check("run_req_count", count, 2);
        check("run_req_valid", rd_valid, 0);
        rd_req = 1'b0;

        // Overflow wrap
        doReset();
        for (int i = 0; i < 20; i++) cap(8'(i), 8'h20);
        cap(8'd20, 8'hE0);
        check("ovf_state", state, 1);
        check("ovf_count", count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_instcnt", inst_cnt, 21);
        for (int i = 0; i < 16; i++) begin
            check("ovf_pc", rd_pc, 5 + i);
            rd_req = 1'b1;
            tick();
        end
        rd_req = 1'b0;
        check("ovf_empty", rd_valid, 0);

        // Watchdog
        doReset();
        for (int i = 0; i < 31; i++) cap(8'(i), 8'h20);
        check("wd_pre_state", state, 0);
        cap(8'd31, 8'h20);
        check("wd_state", state, 2);
        check("wd_done", done, 1);
        check("wd_cyc", cycle_cnt, 32);
        for (int i = 0; i < 5; i++) cap(8'(100 + i), 8'hE0);
        check("wd_frozen_state", state, 2);
        check("wd_frozen_count", count, 16);
        check("wd_frozen_cyc", cycle_cnt, 32);
        check("wd_frozen_inst", inst_cnt, 32);
        check("wd_head", rd_pc, 16);

        // Halt on the TIMEOUT-th capture wins
        doReset();
        for (int i = 0; i < 31; i++) cap(8'(i), 8'h20);
        cap(8'd31, 8'hE0);
        check("wdhalt_state", state, 1);
        check("wdhalt_cyc", cycle_cnt, 32);

        // Write-back capture table
        doReset();
        for (int i = 0; i < 4; i++) begin
            reg_we = wbVecs[i].regWe; reg_wdata = wbVecs[i].regData;
            mem_we = wbVecs[i].memWe; mem_wdata = wbVecs[i].memData;
            cap(8'(8'h80 + i), 8'h20);
        end
        reg_we = 1'b0; mem_we = 1'b0;
        cap(8'h84, 8'hE0);
        check("wb_count", count, 5);
        for (int i = 0; i < 4; i++) begin
            check("wb_pc", rd_pc, 8'h80 + i);
            check("wb_flags", rd_flags, wbVecs[i].expFlags);
            check("wb_data", rd_data, wbVecs[i].expData);
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
        end
        check("wb_halt_flags", rd_flags, 2'b00);
        check("wb_halt_data", rd_data, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
